// File: rtl/mult_div_sequencer.sv
// -----------------------------------------------------------------------------
// mult_div_sequencer
//
// Multi-cycle signed multiply / divide unit that sits beside the single-cycle
// ALU in the execute stage. One operation is accepted in IDLE, processed one
// bit per clock (shift-add for MULT, restoring shift-subtract for DIV) on
// unsigned magnitudes, then sign-corrected and written to HI/LO in a final
// FIX cycle. The pipeline stalls while busy is high.
//
// Ports:
//   clk           in   clock, all state updates on the rising edge
//   rst           in   synchronous active-high reset, aborts any operation
//   start         in   request, only looked at in IDLE
//   alu_operation in   4'd12 = signed mult, 4'd13 = signed div, others ignored
//   operand_a     in   multiplicand / dividend (two's complement)
//   operand_b     in   multiplier / divisor (two's complement)
//   busy          out  high while an operation is in flight
//   done          out  one-cycle pulse when hi/lo carry a new result
//   div_by_zero   out  high with done when the divide had a zero divisor
//   hi            out  mult: upper product half, div: remainder
//   lo            out  mult: lower product half, div: quotient
// -----------------------------------------------------------------------------
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] OP_MULT = 4'd12;
    localparam logic [3:0] OP_DIV  = 4'd13;

    localparam int CNT_W = $clog2(WIDTH + 1);
    // One spare bit on top of the 2W product so the shift-add carry is kept.
    localparam int ACC_W = 2 * WIDTH + 1;

    localparam logic [CNT_W-1:0]   CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which is the correct unsigned magnitude 2^(W-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
        logic [WIDTH-1:0] u;
        u = x;
        return x[WIDTH-1] ? (~u + ONE_W) : u;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x,
                                                    input logic             neg);
        return neg ? (~x + ONE_W) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x,
                                                       input logic               neg);
        return neg ? (~x + ONE_2W) : x;
    endfunction

    // Control state
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Operation context latched at acceptance (not reset: only meaningful
    // while an operation is in flight)
    logic                     is_div_q;
    logic                     neg_prod_q;   // product / quotient sign
    logic                     neg_rem_q;    // remainder sign (dividend sign)
    logic                     b_zero_q;
    logic signed [WIDTH-1:0]  a_raw_q;
    logic [WIDTH-1:0]         a_mag_q;
    logic [WIDTH-1:0]         b_mag_q;

    // Shared iteration register.
    //   mult: acc[2W:W] = partial product high part, acc[W-1:0] = multiplier,
    //         shifted right one bit per step so acc[0] is the current bit.
    //   div:  acc[2W-1:W] = partial remainder, acc[W-1:0] = dividend bits
    //         shifting out at the top while quotient bits enter at the bottom.
    logic [ACC_W-1:0]   acc_q;

    logic [WIDTH:0]       mul_sum_d;
    logic [WIDTH:0]       div_trial_d;
    logic [WIDTH-1:0]     div_diff_d;
    logic                 div_ge_d;
    logic [ACC_W-1:0]     acc_d;
    logic [2*WIDTH-1:0]   prod_d;
    logic [WIDTH-1:0]     quo_d;
    logic [WIDTH-1:0]     rem_d;
    logic                 op_valid_d;

    assign op_valid_d = (alu_operation == OP_MULT) || (alu_operation == OP_DIV);

    // One iteration of either algorithm on the magnitudes
    always_comb begin
        mul_sum_d   = acc_q[ACC_W-1:WIDTH] + (acc_q[0] ? {1'b0, a_mag_q} : {(WIDTH+1){1'b0}});
        div_trial_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge_d    = (div_trial_d >= {1'b0, b_mag_q});
        // Only used when trial >= divisor, so the difference fits in W bits.
        div_diff_d  = div_trial_d[WIDTH-1:0] - b_mag_q;

        if (is_div_q) begin
            acc_d = {1'b0,
                     (div_ge_d ? div_diff_d : div_trial_d[WIDTH-1:0]),
                     acc_q[WIDTH-2:0],
                     div_ge_d};
        end else begin
            acc_d = {1'b0, mul_sum_d, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction applied in FIX
    always_comb begin
        prod_d = cond_neg_2w(acc_q[2*WIDTH-1:0], neg_prod_q);
        quo_d  = cond_neg_w(acc_q[WIDTH-1:0], neg_prod_q);
        rem_d  = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start && op_valid_d) begin
                        is_div_q   <= (alu_operation == OP_DIV);
                        neg_prod_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                        neg_rem_q  <= operand_a[WIDTH-1];
                        b_zero_q   <= (operand_b == '0);
                        a_raw_q    <= operand_a;
                        a_mag_q    <= magnitude(operand_a);
                        b_mag_q    <= magnitude(operand_b);
                        // Seed the low half with the operand that gets
                        // consumed bit by bit: multiplier or dividend.
                        acc_q      <= {{(WIDTH+1){1'b0}},
                                       (alu_operation == OP_DIV) ? magnitude(operand_a)
                                                                 : magnitude(operand_b)};
                        cnt_q      <= CNT_INIT;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end

                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= FIX;
                    end
                end

                FIX: begin
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= prod_d;
                    end else if (b_zero_q) begin
                        // Zero divisor: all-ones quotient, dividend passed
                        // through unchanged as the remainder.
                        hi_q <= a_raw_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem_d;
                        lo_q <= quo_d;
                    end
                    done_q  <= 1'b1;
                    dbz_q   <= is_div_q && b_zero_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
